// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: IR field layout,
// opcode map, FSM state encoding and opcode classification helpers.
package cpu_ctrl_pkg;

  localparam int unsigned IR_W     = 32;
  localparam int unsigned OP_W     = 5;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned STEP_W   = 3;

  // IR field positions (LSB of each field)
  localparam int unsigned IR_OP_LSB = 27;
  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_LSB = 15;

  // Opcode map
  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // ALU code used for effective-address calculation
  localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

  // FSM state encoding; F0..E4 are contiguous so "running" is a range test
  localparam logic [STATE_W-1:0] ST_RST  = 4'd0;
  localparam logic [STATE_W-1:0] ST_F0   = 4'd1;
  localparam logic [STATE_W-1:0] ST_F1   = 4'd2;
  localparam logic [STATE_W-1:0] ST_F2   = 4'd3;
  localparam logic [STATE_W-1:0] ST_F3   = 4'd4;
  localparam logic [STATE_W-1:0] ST_E0   = 4'd5;
  localparam logic [STATE_W-1:0] ST_E1   = 4'd6;
  localparam logic [STATE_W-1:0] ST_E2   = 4'd7;
  localparam logic [STATE_W-1:0] ST_E3   = 4'd8;
  localparam logic [STATE_W-1:0] ST_E4   = 4'd9;
  localparam logic [STATE_W-1:0] ST_HALT = 4'd10;

  // Decoded IR fields
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
  } ir_fields_t;

  // Instruction families sharing one execute sequence
  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_IMM,
    CLS_LD,
    CLS_ST,
    CLS_MULDIV,
    CLS_MFHI,
    CLS_MFLO,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [OP_W-1:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHL: cls = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       cls = CLS_IMM;
      OP_LD:                          cls = CLS_LD;
      OP_ST:                          cls = CLS_ST;
      OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
      OP_MFHI:                        cls = CLS_MFHI;
      OP_MFLO:                        cls = CLS_MFLO;
      OP_NOP:                         cls = CLS_NOP;
      OP_HALT:                        cls = CLS_HALT;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Index of the final execute step (E0 = 0) for each family
  function automatic logic [STEP_W-1:0] last_exec_step(input op_class_e cls);
    logic [STEP_W-1:0] last;
    case (cls)
      CLS_RTYPE, CLS_IMM: last = 3'd2;
      CLS_LD, CLS_ST:     last = 3'd4;
      CLS_MULDIV:         last = 3'd3;
      default:            last = 3'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register-select decoder: 4-bit register field plus enable to a one-hot
// 16-bit select. All zeros when disabled.
//   sel    : register number
//   en     : produce a select this cycle
//   onehot : bit n set selects Rn
module reg_select_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [REG_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: steps fetch (F0-F3) and execute (E0-E4) one
// control step per clock, Moore-decoding every datapath strobe from the state
// register and the IR. Memory steps stall on mem_rdy, with an optional
// timeout that halts and raises a sticky bus error.
//   clk, clr   : clock, asynchronous active-low reset
//   ir         : instruction register contents (valid from E0)
//   mem_rdy    : current Read/Write completes this cycle
//   rin, rout  : one-hot register write enable / bus drive
//   PCin..Write: datapath strobes
//   alu_op     : ALU operation
//   run        : high while sequencing
//   bus_err    : sticky memory timeout
//   illegal_op : sticky undecodable opcode
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned WAIT_W     = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [IR_W-1:0]     ir,
  input  logic                mem_rdy,
  output logic [NUM_REGS-1:0] rin,
  output logic [NUM_REGS-1:0] rout,
  output logic                PCin,
  output logic                PCout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                HIin,
  output logic                HIout,
  output logic                LOin,
  output logic                LOout,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                IncPC,
  output logic                Cout,
  output logic                Read,
  output logic                Write,
  output logic [OP_W-1:0]     alu_op,
  output logic                run,
  output logic                bus_err,
  output logic                illegal_op
);

  // A wait step with mem_rdy low in this cycle is the last one allowed
  localparam bit                WAIT_BOUNDED = (WAIT_LIMIT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(WAIT_LIMIT - 1);

  logic [STATE_W-1:0] state_q, state_d, step_next;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               bus_err_q, illegal_q;
  logic               bus_err_set, illegal_set;
  logic               mem_wait, wait_expired;
  logic               rin_en, rout_en;
  logic [REG_W-1:0]   rin_sel, rout_sel;
  ir_fields_t         fld;
  op_class_e          cls;
  logic [STEP_W-1:0]  last_step;
  logic               unused_ir;

  // IR field extraction and instruction family lookup
  assign fld       = {ir[IR_OP_LSB +: OP_W], ir[IR_RA_LSB +: REG_W],
                      ir[IR_RB_LSB +: REG_W], ir[IR_RC_LSB +: REG_W]};
  assign unused_ir = ^ir[IR_RC_LSB-1:0];
  assign cls       = classify(fld.op);
  assign last_step = last_exec_step(cls);

  assign wait_expired = WAIT_BOUNDED && (wait_q == WAIT_LAST);
  assign bus_err      = bus_err_q;
  assign illegal_op   = illegal_q;

  // State, wait counter and sticky flags
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_RST;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (bus_err_set) bus_err_q <= 1'b1;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  // Next-state and Moore strobe decode
  always_comb begin
    state_d     = state_q;
    step_next   = state_q;
    wait_d      = wait_q;
    mem_wait    = 1'b0;
    bus_err_set = 1'b0;
    illegal_set = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rin_sel     = fld.ra;
    rout_sel    = fld.rb;
    PCin        = 1'b0;
    PCout       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    HIin        = 1'b0;
    HIout       = 1'b0;
    LOin        = 1'b0;
    LOout       = 1'b0;
    Zhighout    = 1'b0;
    Zlowout     = 1'b0;
    IncPC       = 1'b0;
    Cout        = 1'b0;
    Read        = 1'b0;
    Write       = 1'b0;
    alu_op      = '0;
    run         = (state_q >= ST_F0) && (state_q <= ST_E4);

    case (state_q)
      ST_RST: step_next = ST_F0;

      ST_F0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        IncPC     = 1'b1;
        Zin       = 1'b1;
        step_next = ST_F1;
      end

      ST_F1: begin
        Zlowout   = 1'b1;
        PCin      = 1'b1;
        step_next = ST_F2;
      end

      ST_F2: begin
        Read      = 1'b1;
        MDRin     = 1'b1;
        mem_wait  = 1'b1;
        step_next = ST_F3;
      end

      ST_F3: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        step_next = ST_E0;
      end

      ST_E0: begin
        case (cls)
          CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST: begin
            rout_en = 1'b1;
            Yin     = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en  = 1'b1;
            rout_sel = fld.ra;
            Yin      = 1'b1;
          end
          CLS_MFHI: begin
            HIout  = 1'b1;
            rin_en = 1'b1;
          end
          CLS_MFLO: begin
            LOout  = 1'b1;
            rin_en = 1'b1;
          end
          CLS_ILLEGAL: illegal_set = 1'b1;
          default: ;
        endcase
        if (cls == CLS_HALT || cls == CLS_ILLEGAL) step_next = ST_HALT;
        else if (last_step == 3'd0)                step_next = ST_F0;
        else                                       step_next = ST_E1;
      end

      ST_E1: begin
        Zin = 1'b1;
        case (cls)
          CLS_RTYPE: begin
            rout_en  = 1'b1;
            rout_sel = fld.rc;
            alu_op   = fld.op;
          end
          CLS_IMM: begin
            Cout   = 1'b1;
            alu_op = fld.op;
          end
          CLS_LD, CLS_ST: begin
            Cout   = 1'b1;
            alu_op = ALU_ADD;
          end
          CLS_MULDIV: begin
            rout_en = 1'b1;
            alu_op  = fld.op;
          end
          default: Zin = 1'b0;
        endcase
        step_next = ST_E2;
      end

      ST_E2: begin
        Zlowout = 1'b1;
        case (cls)
          CLS_RTYPE, CLS_IMM: rin_en  = 1'b1;
          CLS_LD, CLS_ST:     MARin   = 1'b1;
          CLS_MULDIV:         LOin    = 1'b1;
          default:            Zlowout = 1'b0;
        endcase
        step_next = (last_step == 3'd2) ? ST_F0 : ST_E3;
      end

      ST_E3: begin
        case (cls)
          CLS_LD: begin
            Read     = 1'b1;
            MDRin    = 1'b1;
            mem_wait = 1'b1;
          end
          CLS_ST: begin
            rout_en  = 1'b1;
            rout_sel = fld.ra;
            MDRin    = 1'b1;
          end
          CLS_MULDIV: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
          end
          default: ;
        endcase
        step_next = (last_step == 3'd3) ? ST_F0 : ST_E4;
      end

      ST_E4: begin
        case (cls)
          CLS_LD: begin
            MDRout = 1'b1;
            rin_en = 1'b1;
          end
          CLS_ST: begin
            Write    = 1'b1;
            mem_wait = 1'b1;
          end
          default: ;
        endcase
        step_next = ST_F0;
      end

      ST_HALT: step_next = ST_HALT;

      default: step_next = ST_HALT;
    endcase

    // Memory steps hold until mem_rdy; a bounded wait that runs out halts
    if (mem_wait && !mem_rdy) begin
      if (wait_expired) begin
        state_d     = ST_HALT;
        wait_d      = '0;
        bus_err_set = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end else begin
      state_d = step_next;
      wait_d  = '0;
    end
  end

  reg_select_decoder u_rin_dec (
    .sel    (rin_sel),
    .en     (rin_en),
    .onehot (rin)
  );

  reg_select_decoder u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer. A per-instruction
// model expands each instruction into its list of expected control steps
// (including memory wait cycles) and the bench replays it cycle by cycle.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, HIout;
    logic LOin, LOout, Zhighout, Zlowout, IncPC, Cout, Read, Write;
    logic [4:0]  alu_op;
    logic run, bus_err, illegal_op;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, clr_l, mem_rdy, rdy_l;
  logic [31:0] ir, ir_l;

  logic [15:0] rin, rout, rin_l, rout_l;
  logic [4:0]  alu_op, alu_op_l;
  logic PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, HIout;
  logic LOin, LOout, Zhighout, Zlowout, IncPC, Cout, Read, Write;
  logic run, bus_err, illegal_op;
  logic PCin_l, PCout_l, IRin_l, Yin_l, Zin_l, MARin_l, MDRin_l, MDRout_l, HIin_l, HIout_l;
  logic LOin_l, LOout_l, Zhighout_l, Zlowout_l, IncPC_l, Cout_l, Read_l, Write_l;
  logic run_l, bus_err_l, illegal_op_l;

  ctl_t obs, obs_l;
  assign obs = {rin, rout, PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, HIout,
                LOin, LOout, Zhighout, Zlowout, IncPC, Cout, Read, Write, alu_op,
                run, bus_err, illegal_op};
  assign obs_l = {rin_l, rout_l, PCin_l, PCout_l, IRin_l, Yin_l, Zin_l, MARin_l, MDRin_l,
                  MDRout_l, HIin_l, HIout_l, LOin_l, LOout_l, Zhighout_l, Zlowout_l,
                  IncPC_l, Cout_l, Read_l, Write_l, alu_op_l, run_l, bus_err_l, illegal_op_l};

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy), .rin(rin), .rout(rout),
    .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin), .HIout(HIout), .LOin(LOin),
    .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .IncPC(IncPC), .Cout(Cout),
    .Read(Read), .Write(Write), .alu_op(alu_op), .run(run), .bus_err(bus_err),
    .illegal_op(illegal_op)
  );

  control_sequencer #(.WAIT_LIMIT(4), .WAIT_W(8)) dut_lim (
    .clk(clk), .clr(clr_l), .ir(ir_l), .mem_rdy(rdy_l), .rin(rin_l), .rout(rout_l),
    .PCin(PCin_l), .PCout(PCout_l), .IRin(IRin_l), .Yin(Yin_l), .Zin(Zin_l),
    .MARin(MARin_l), .MDRin(MDRin_l), .MDRout(MDRout_l), .HIin(HIin_l),
    .HIout(HIout_l), .LOin(LOin_l), .LOout(LOout_l), .Zhighout(Zhighout_l),
    .Zlowout(Zlowout_l), .IncPC(IncPC_l), .Cout(Cout_l), .Read(Read_l),
    .Write(Write_l), .alu_op(alu_op_l), .run(run_l), .bus_err(bus_err_l),
    .illegal_op(illegal_op_l)
  );

  int n_checks = 0;
  int n_errors = 0;

  ctl_t        exp_q[$];
  logic        rdy_q[$];
  logic [31:0] ir_q[$];
  string       tag_q[$];
  logic [31:0] cur_ir;
  string       cur_tag;
  int          ins_no = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] oh(input logic [3:0] n);
    return 16'(1) << n;
  endfunction

  function automatic ctl_t live();
    ctl_t c;
    c     = '0;
    c.run = 1'b1;
    return c;
  endfunction

  // 0 R-type, 1 immediate, 2 ld, 3 st, 4 mul/div, 5 mfhi, 6 mflo, 7 nop, 8 halt, 9 undefined
  function automatic int op_kind(input logic [4:0] op);
    int o;
    o = int'(op);
    if (o >= 3 && o <= 10) return 0;
    if (o >= 12 && o <= 14) return 1;
    if (o == 0) return 2;
    if (o == 2) return 3;
    if (o == 15 || o == 16) return 4;
    if (o == 23) return 5;
    if (o == 24) return 6;
    if (o == 26) return 7;
    if (o == 27) return 8;
    return 9;
  endfunction

  task automatic push(input string step, input ctl_t e, input logic rdy);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    ir_q.push_back(cur_ir);
    tag_q.push_back({cur_tag, "_", step});
  endtask

  // Non-memory steps get a random mem_rdy: the step must not care
  task automatic push_any(input string step, input ctl_t e);
    push(step, e, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_mem(input string step, input ctl_t e, input int d);
    for (int k = 0; k < d; k++) push(step, e, 1'b0);
    push(step, e, 1'b1);
  endtask

  task automatic push_halted(input int n, input logic be, input logic ill);
    ctl_t c;
    c            = '0;
    c.bus_err    = be;
    c.illegal_op = ill;
    for (int k = 0; k < n; k++) push_any("HALT", c);
  endtask

  task automatic push_fetch_head(input logic [4:0] op, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic [3:0] rc);
    ctl_t c;
    ins_no++;
    cur_ir  = {op, ra, rb, rc, 15'($urandom)};
    cur_tag = $sformatf("i%0d_op%0d", ins_no, op);
    c = live(); c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1; push_any("F0", c);
    c = live(); c.Zlowout = 1; c.PCin = 1; push_any("F1", c);
  endtask

  task automatic add_insn(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rc, input int d_f2, input int d_mem);
    ctl_t c;
    int   k;
    k = op_kind(op);
    push_fetch_head(op, ra, rb, rc);
    c = live(); c.Read = 1; c.MDRin = 1; push_mem("F2", c, d_f2);
    c = live(); c.MDRout = 1; c.IRin = 1; push_any("F3", c);
    case (k)
      0, 1: begin
        c = live(); c.rout = oh(rb); c.Yin = 1; push_any("E0", c);
        c = live(); c.alu_op = op; c.Zin = 1;
        if (k == 0) c.rout = oh(rc); else c.Cout = 1;
        push_any("E1", c);
        c = live(); c.Zlowout = 1; c.rin = oh(ra); push_any("E2", c);
      end
      2, 3: begin
        c = live(); c.rout = oh(rb); c.Yin = 1; push_any("E0", c);
        c = live(); c.Cout = 1; c.alu_op = 5'b00011; c.Zin = 1; push_any("E1", c);
        c = live(); c.Zlowout = 1; c.MARin = 1; push_any("E2", c);
        if (k == 2) begin
          c = live(); c.Read = 1; c.MDRin = 1; push_mem("E3", c, d_mem);
          c = live(); c.MDRout = 1; c.rin = oh(ra); push_any("E4", c);
        end else begin
          c = live(); c.rout = oh(ra); c.MDRin = 1; push_any("E3", c);
          c = live(); c.Write = 1; push_mem("E4", c, d_mem);
        end
      end
      4: begin
        c = live(); c.rout = oh(ra); c.Yin = 1; push_any("E0", c);
        c = live(); c.rout = oh(rb); c.alu_op = op; c.Zin = 1; push_any("E1", c);
        c = live(); c.Zlowout = 1; c.LOin = 1; push_any("E2", c);
        c = live(); c.Zhighout = 1; c.HIin = 1; push_any("E3", c);
      end
      5: begin
        c = live(); c.HIout = 1; c.rin = oh(ra); push_any("E0", c);
      end
      6: begin
        c = live(); c.LOout = 1; c.rin = oh(ra); push_any("E0", c);
      end
      default: push_any("E0", live());
    endcase
  endtask

  // Replay up to n queued steps against one of the two instances
  task automatic drain(input bit lim, input int n);
    ctl_t  e;
    logic  r;
    logic [31:0] i;
    string t;
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      i = ir_q.pop_front();
      t = tag_q.pop_front();
      if (lim) begin rdy_l = r; ir_l = i; end
      else     begin mem_rdy = r; ir = i; end
      @(negedge clk);
      check_eq(t, lim ? 64'(obs_l) : 64'(obs), 64'(e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit lim, input int n);
    if (lim) clr_l = 1'b0; else clr = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq($sformatf("%s_rst%0d", lim ? "lim" : "main", k),
               lim ? 64'(obs_l) : 64'(obs), 64'd0);
      @(posedge clk);
      #1;
    end
    if (lim) clr_l = 1'b1; else clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] legal_ops [17] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd23, 5'd24};

  function automatic int rand_delay();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(4, 9));
    return int'($urandom_range(0, 2));
  endfunction

  initial begin
    clr = 1'b0; clr_l = 1'b0; mem_rdy = 1'b0; rdy_l = 1'b0; ir = '0; ir_l = '0;

    do_reset(1'b0, 3);

    // add r3,r1,r2 with memory always ready
    add_insn(5'd3, 4'd3, 4'd1, 4'd2, 0, 0);
    drain(1'b0, 1000);
    // ld r4 via r2: 3 wait cycles in F2, 2 in E3
    add_insn(5'd0, 4'd4, 4'd2, 4'($urandom), 3, 2);
    drain(1'b0, 1000);
    // st r5 via r2
    add_insn(5'd2, 4'd5, 4'd2, 4'($urandom), 1, 3);
    drain(1'b0, 1000);

    // random instruction stream, unbounded waits
    for (int n = 0; n < 60; n++) begin
      add_insn(legal_ops[$urandom_range(0, 16)], 4'($urandom), 4'($urandom), 4'($urandom),
               rand_delay(), rand_delay());
      drain(1'b0, 1000);
    end

    // halt: stops with no flags, held until reset
    add_insn(5'd27, 4'($urandom), 4'($urandom), 4'($urandom), 0, 0);
    push_halted(4, 1'b0, 1'b0);
    drain(1'b0, 1000);
    do_reset(1'b0, 2);

    // undefined opcode
    add_insn(5'd31, 4'($urandom), 4'($urandom), 4'($urandom), 1, 0);
    push_halted(3, 1'b0, 1'b1);
    drain(1'b0, 1000);
    do_reset(1'b0, 1);

    // reset in the middle of a stalled ld E3
    add_insn(5'd0, 4'd6, 4'd1, 4'd0, 0, 20);
    drain(1'b0, 9);
    mem_rdy = 1'b0;
    #1;
    check_eq("pre_rst_read", 64'(Read), 64'd1);
    #1;
    clr = 1'b0;
    #1;
    check_eq("mid_rst_async", 64'(obs), 64'd0);
    exp_q.delete(); rdy_q.delete(); ir_q.delete(); tag_q.delete();
    do_reset(1'b0, 2);
    add_insn(legal_ops[$urandom_range(0, 16)], 4'($urandom), 4'($urandom), 4'($urandom), 1, 1);
    drain(1'b0, 1000);

    // bounded-wait instance: waits just inside the limit complete normally
    do_reset(1'b1, 2);
    add_insn(5'd3, 4'd7, 4'd8, 4'd9, 3, 0);
    drain(1'b1, 1000);
    add_insn(5'd0, 4'd1, 4'd2, 4'd3, 0, 3);
    drain(1'b1, 1000);
    add_insn(5'd2, 4'd10, 4'd11, 4'd0, 2, 3);
    drain(1'b1, 1000);

    // mem_rdy never arrives: 4 wait cycles in F2, then bus error halt
    begin
      ctl_t c;
      push_fetch_head(5'd3, 4'd1, 4'd2, 4'd3);
      c = live(); c.Read = 1; c.MDRin = 1;
      for (int k = 0; k < 4; k++) push("F2", c, 1'b0);
      push_halted(5, 1'b1, 1'b0);
    end
    drain(1'b1, 1000);
    do_reset(1'b1, 1);
    add_insn(5'd12, 4'd2, 4'd5, 4'd0, 0, 0);
    drain(1'b1, 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives every control strobe the datapath consumes: register in/out selects, PC/IR/Y/Z/MAR/MDR/HI/LO strobes, ALU op, memory Read/Write.
- Sequences fetch and execute, one control step per clock.
- Decodes the instruction held in IR.
- Holds the current step while the memory responder deasserts mem_rdy.

Parameters:
- WAIT_LIMIT, 0: maximum cycles spent waiting on mem_rdy per access. 0 means wait forever. Nonzero: exceeding it is a bus error.
- WAIT_W, 8: width of the wait counter. WAIT_LIMIT must be < 2**WAIT_W.

Ports:
- clk  in  1  single system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- ir  in  32  IR contents. op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- mem_rdy  in  1  memory responder completed the current Read/Write this cycle.
- rin  out  16  one-hot register write enable, bit n maps to Rn.
- rout  out  16  one-hot register bus drive, bit n maps to Rn.
- PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, HIout, LOin, LOout, Zhighout, Zlowout, IncPC, Cout, Read, Write  out  1 each  datapath strobes.
- alu_op  out  5  ALU operation. Equals op during ALU steps, 5'b00011 (ADD) for address calculation, 0 otherwise.
- run  out  1  high unless halted.
- bus_err  out  1  sticky; set on memory wait timeout.
- illegal_op  out  1  sticky; set on undecodable opcode.

Behaviour:
- Reset (clr=0, async): state RST, all outputs 0 except run=0; wait counter 0; sticky flags cleared.
- First rising edge with clr=1 moves RST to F0.
- Outputs are Moore-decoded from the state register plus the registered ir. No output depends combinationally on mem_rdy.
- Fetch:
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin.
  - F2: Read, MDRin. Hold while mem_rdy=0.
  - F3: MDRout, IRin.
  - Then E0. ir is sampled valid from E0 onward.
- Opcodes and execute steps:
  - ld=00000, st=00010.
  - ALU R-type: add=00011, sub=00100, and=00101, or=00110, ror=00111, rol=01000, shr=01001, shl=01010.
  - Immediate: addi=01100, andi=01101, ori=01110.
  - mul=01111, div=10000, mfhi=10111, mflo=11000, nop=11010, halt=11011.
  - R-type: E0 rout[rb], Yin. E1 rout[rc], alu_op=op, Zin. E2 Zlowout, rin[ra].
  - Immediate: as R-type, but E1 uses Cout instead of rout[rc].
  - ld: E0 rout[rb], Yin. E1 Cout, alu_op=ADD, Zin. E2 Zlowout, MARin. E3 Read, MDRin, hold until mem_rdy. E4 MDRout, rin[ra].
  - st: E0–E2 as ld. E3 rout[ra], MDRin, Read=0. E4 Write, hold until mem_rdy.
  - mul/div: E0 rout[ra], Yin. E1 rout[rb], alu_op=op, Zin. E2 Zlowout, LOin. E3 Zhighout, HIin.
  - mfhi: E0 HIout, rin[ra]. mflo: E0 LOout, rin[ra].
  - nop: E0 with no strobes.
  - halt: E0 then HALT.
  - Last execute step always returns to F0.
- Memory wait (F2, ld E3, st E4):
  - Read/Write and MDRin stay asserted every cycle of the wait.
  - The step advances on the edge where mem_rdy=1.
  - The wait counter increments each cycle mem_rdy=0 and clears on step exit.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT with mem_rdy still 0: next state HALT, bus_err=1.
- Undefined opcode: at E0 no strobes, set illegal_op, next state HALT.
- HALT: all strobes 0, run=0. Held until clr asserts.
- Exactly one bit of rin/rout is set in any step that uses them, otherwise 0. Never more than one bus driver is asserted per cycle.
- Reset mid-access: Read/Write drop asynchronously; the aborted instruction has no further effect.

Decomposition:
- Package cpu_ctrl_pkg: opcode constants, state enum (RST, F0–F3, E0–E4, HALT), IR field bit positions, ALU_ADD constant.
- Sub-module reg_select_decoder: 4-bit field plus enable to 16-bit one-hot. Instantiated twice, for rin and rout.

Test Plan:
- Reset/start: clr low for 3 cycles then high. All outputs 0 during reset. F0 strobes (PCout, MARin, IncPC, Zin) appear in the first cycle after release.
- add r3,r1,r2 with mem_rdy tied high: 7 cycles F0→E2. E0 rout=0x0002, Yin. E1 rout=0x0004, alu_op=00011, Zin. E2 rin=0x0008, Zlowout. Back to F0.
- ld r4 via r2, mem_rdy delayed 3 cycles in F2 and 2 in E3: Read/MDRin held high 4 and 3 cycles respectively. E1 alu_op=00011 with Cout. E4 rin=0x0010. Total 14 cycles.
- st r5 via r2: E3 rout=0x0020, MDRin, Read=0. E4 Write held until mem_rdy.
- WAIT_LIMIT=4, mem_rdy never asserted: after 4 wait cycles in F2 → HALT, bus_err=1, run=0, Read=0. Stays there until clr.
- Opcode 11111 → illegal_op=1, HALT. halt opcode → run=0 with no flags set. clr asserted mid-E3 of ld clears everything immediately, then restarts at F0.
